// File: rtl/mesh_edge_gateway_if.sv
// Signal bundle between client ports, the router injection link and the response return path.
// Every request channel uses valid/ready: a beat transfers on a rising edge where both are high, and the sender holds all fields stable until then.
interface mesh_edge_gateway_if #(
    parameter int N_PORTS    = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 2
);
    logic [N_PORTS-1:0]            req_valid;
    logic [N_PORTS-1:0]            req_ready;
    logic [N_PORTS-1:0]            req_write;
    logic [N_PORTS*ADDR_W-1:0]     req_addr;
    logic [N_PORTS*DATA_WIDTH-1:0] req_data;

    logic                          link_valid;
    logic                          link_ready;
    logic                          link_write;
    logic                          link_read;
    logic [ADDR_W-1:0]             link_addr;
    logic [DATA_WIDTH-1:0]         link_data;
    logic [TAG_W-1:0]              link_tag;

    logic                          rsp_valid;
    logic [TAG_W-1:0]              rsp_tag;
    logic [DATA_WIDTH-1:0]         rsp_data;

    logic [N_PORTS-1:0]            readReady;
    logic [N_PORTS*DATA_WIDTH-1:0] dataOut;
    logic [N_PORTS-1:0]            rd_timeout;
    logic                          rsp_unexpected;
    logic [N_PORTS-1:0]            dbgWaitRsp;

    modport slave (
        input  req_valid, req_write, req_addr, req_data, link_ready,
        input  rsp_valid, rsp_tag, rsp_data,
        output req_ready, link_valid, link_write, link_read, link_addr, link_data, link_tag,
        output readReady, dataOut, rd_timeout, rsp_unexpected, dbgWaitRsp
    );

    modport master (
        output req_valid, req_write, req_addr, req_data, link_ready,
        output rsp_valid, rsp_tag, rsp_data,
        input  req_ready, link_valid, link_write, link_read, link_addr, link_data, link_tag,
        input  readReady, dataOut, rd_timeout, rsp_unexpected, dbgWaitRsp
    );
endinterface

// File: rtl/mesh_edge_gateway.sv
// Access-port front end: per-port request FIFOs, round-robin injection onto one router link,
// and per-port single outstanding read tracking with response matching and timeout.
module mesh_edge_gateway #(
    parameter int N_PORTS         = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int NET_ADDR_WIDTH  = 4,
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic               clk,
    input  logic               reset,
    mesh_edge_gateway_if.slave bus
);
    localparam int ADDR_W = NET_ADDR_WIDTH + BANK_ADDR_WIDTH;
    localparam int TAG_W  = $clog2(N_PORTS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE = 1'b0, WAIT_RSP = 1'b1} portState_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_WIDTH-1:0] data;
    } reqEntry_t;

    reqEntry_t                     fifoMem [N_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]              rdPtr [N_PORTS];
    logic [PTR_W-1:0]              wrPtr [N_PORTS];
    logic [CNT_W-1:0]              count [N_PORTS];
    logic [TMR_W-1:0]              timer [N_PORTS];
    portState_t                    portState [N_PORTS];
    portState_t                    portStateNext [N_PORTS];

    logic [TAG_W-1:0]              rrPtr;
    logic                          linkValid;
    reqEntry_t                     linkEntry;
    logic [TAG_W-1:0]              linkTag;

    logic [N_PORTS-1:0]            reqReady, push, pop, eligible, accepted, rspHit, timeoutHit;
    logic [N_PORTS-1:0]            readReadyReg, rdTimeoutReg;
    logic [N_PORTS*DATA_WIDTH-1:0] dataOutReg;
    logic                          rspUnexpectedReg;
    logic                          grantValid;
    logic [TAG_W-1:0]              grantIdx;
    logic                          linkAccept, canLoad;
    int                            idx;

    assign linkAccept = linkValid & bus.link_ready;
    assign canLoad    = ~linkValid | bus.link_ready;

    always_comb begin
        reqReady   = '0;
        push       = '0;
        eligible   = '0;
        accepted   = '0;
        rspHit     = '0;
        timeoutHit = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            reqReady[p] = (count[p] != CNT_W'(FIFO_DEPTH));
            push[p]     = bus.req_valid[p] & reqReady[p];
            // A held read keeps its port out of arbitration until it is accepted and the port waits.
            eligible[p] = (count[p] != '0) && (portState[p] == IDLE) &&
                          !(linkValid && !linkEntry.write && (linkTag == TAG_W'(p)));
            accepted[p] = linkAccept && !linkEntry.write && (linkTag == TAG_W'(p));
            rspHit[p]   = bus.rsp_valid && (bus.rsp_tag == TAG_W'(p)) && (portState[p] == WAIT_RSP);
            timeoutHit[p] = (portState[p] == WAIT_RSP) && !rspHit[p] &&
                            (timer[p] == TMR_W'(TIMEOUT_CYCLES - 1));
        end
    end

    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        idx        = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = (int'(rrPtr) + k) % N_PORTS;
            if (!grantValid && eligible[idx]) begin
                grantValid = 1'b1;
                grantIdx   = TAG_W'(idx);
            end
        end
        pop = '0;
        if (canLoad && grantValid) pop[grantIdx] = 1'b1;
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            portStateNext[p] = portState[p];
            case (portState[p])
                IDLE:     if (accepted[p]) portStateNext[p] = WAIT_RSP;
                WAIT_RSP: if (rspHit[p] || timeoutHit[p]) portStateNext[p] = IDLE;
                default:  portStateNext[p] = IDLE;
            endcase
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the counters below.
    always_ff @(posedge clk) begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (push[p]) begin
                fifoMem[p][wrPtr[p]] <= '{write: bus.req_write[p],
                                          addr:  bus.req_addr[p*ADDR_W +: ADDR_W],
                                          data:  bus.req_data[p*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < N_PORTS; p++) begin
                portState[p] <= IDLE;
                rdPtr[p]     <= '0;
                wrPtr[p]     <= '0;
                count[p]     <= '0;
                timer[p]     <= '0;
            end
            rrPtr            <= '0;
            linkValid        <= 1'b0;
            linkEntry        <= '0;
            linkTag          <= '0;
            readReadyReg     <= '0;
            rdTimeoutReg     <= '0;
            dataOutReg       <= '0;
            rspUnexpectedReg <= 1'b0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                portState[p] <= portStateNext[p];
                if (push[p]) wrPtr[p] <= wrPtr[p] + PTR_W'(1);
                if (pop[p])  rdPtr[p] <= rdPtr[p] + PTR_W'(1);
                count[p] <= count[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
                if (accepted[p])                  timer[p] <= '0;
                else if (portState[p] == WAIT_RSP) timer[p] <= timer[p] + TMR_W'(1);
                readReadyReg[p] <= rspHit[p];
                rdTimeoutReg[p] <= timeoutHit[p];
                if (rspHit[p]) dataOutReg[p*DATA_WIDTH +: DATA_WIDTH] <= bus.rsp_data;
            end
            // Any response that matched no waiting port is dropped, including out-of-range tags.
            rspUnexpectedReg <= bus.rsp_valid && (rspHit == '0);
            if (canLoad) begin
                linkValid <= grantValid;
                if (grantValid) begin
                    linkEntry <= fifoMem[grantIdx][rdPtr[grantIdx]];
                    linkTag   <= grantIdx;
                    rrPtr     <= (grantIdx == TAG_W'(N_PORTS - 1)) ? '0 : grantIdx + TAG_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) bus.dbgWaitRsp[p] = (portState[p] == WAIT_RSP);
    end

    assign bus.req_ready      = reqReady;
    assign bus.link_valid     = linkValid;
    assign bus.link_write     = linkEntry.write;
    assign bus.link_read      = linkValid & ~linkEntry.write;
    assign bus.link_addr      = linkEntry.addr;
    assign bus.link_data      = linkEntry.data;
    assign bus.link_tag       = linkTag;
    assign bus.readReady      = readReadyReg;
    assign bus.dataOut        = dataOutReg;
    assign bus.rd_timeout     = rdTimeoutReg;
    assign bus.rsp_unexpected = rspUnexpectedReg;
endmodule

// File: tb/tb_mesh_edge_gateway.sv
// Directed bench for mesh_edge_gateway: reset, round-robin issue, backpressure, read return,
// timeout, response/timeout race and mid-operation reset.
module tb_mesh_edge_gateway;
    localparam int NP = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int TO = 64;
    localparam int LW = TW + 1 + AW + DW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] expWord;

    mesh_edge_gateway_if #(.N_PORTS(NP), .ADDR_W(AW), .DATA_WIDTH(DW), .TAG_W(TW)) bus ();

    mesh_edge_gateway #(
        .N_PORTS(NP), .FIFO_DEPTH(4), .NET_ADDR_WIDTH(4), .BANK_ADDR_WIDTH(8),
        .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks; every step leaves the bench 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int p, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.req_valid[p] = 1'b1;
        bus.req_write[p] = wr;
        bus.req_addr[p*AW +: AW] = addr;
        bus.req_data[p*DW +: DW] = data;
    endtask

    task automatic sendRsp(input logic [TW-1:0] tag, input logic [DW-1:0] data);
        bus.rsp_valid = 1'b1;
        bus.rsp_tag = tag;
        bus.rsp_data = data;
        step();
        bus.rsp_valid = 1'b0;
    endtask

    // Scoreboard
    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] linkWord();
        return {bus.link_tag, bus.link_write, bus.link_addr, bus.link_data};
    endfunction

    function automatic logic [LW-1:0] mkWord(input int tag, input logic wr, input logic [AW-1:0] addr,
                                             input logic [DW-1:0] data);
        return {TW'(tag), wr, addr, data};
    endfunction

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.link_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_tag = '0;
        bus.rsp_data = '0;

        // 1: reset holds outputs quiet even with requests offered
        bus.req_valid = '1;
        bus.req_write = '1;
        repeat (3) step();
        check("rst_req_ready", 64'(bus.req_ready), 64'hF);
        check("rst_link_valid", 64'(bus.link_valid), 64'h0);
        check("rst_readReady", 64'(bus.readReady), 64'h0);
        check("rst_timeout", 64'(bus.rd_timeout), 64'h0);
        check("rst_dataOut", 64'(bus.dataOut[DW-1:0]), 64'h0);
        bus.req_valid = '0;
        reset = 1'b1;
        repeat (2) step();
        check("post_rst_link_valid", 64'(bus.link_valid), 64'h0);
        check("post_rst_req_ready", 64'(bus.req_ready), 64'hF);

        // 2: round robin, all ports push one write at once
        bus.link_ready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            setReq(p, 1'b1, AW'(12'h010 + p), DW'(32'h1000 + p));
            exp_q.push_back(mkWord(p, 1'b1, AW'(12'h010 + p), DW'(32'h1000 + p)));
        end
        step();
        bus.req_valid = '0;
        check("rr_latency", 64'(bus.link_valid), 64'h0);
        for (int k = 0; k < NP; k++) begin
            step();
            expWord = exp_q.pop_front();
            check("rr_valid", 64'(bus.link_valid), 64'h1);
            check("rr_word", 64'(linkWord()), 64'(expWord));
        end
        step();
        check("rr_idle", 64'(bus.link_valid), 64'h0);

        // 3: port0 holds the stalled link, port1 fills its FIFO
        bus.link_ready = 1'b0;
        setReq(0, 1'b1, 12'h0A0, 32'h0000_00A0);
        exp_q.push_back(mkWord(0, 1'b1, 12'h0A0, 32'h0000_00A0));
        step();
        bus.req_valid = '0;
        step();
        check("bp_held_valid", 64'(bus.link_valid), 64'h1);
        for (int i = 0; i < 5; i++) begin
            setReq(1, 1'b1, AW'(12'h100 + i), DW'(32'hB00 + i));
            check("bp_req_ready", 64'(bus.req_ready[1]), (i < 4) ? 64'h1 : 64'h0);
            if (i < 4) exp_q.push_back(mkWord(1, 1'b1, AW'(12'h100 + i), DW'(32'hB00 + i)));
            step();
        end
        bus.req_valid = '0;
        check("bp_full", 64'(bus.req_ready[1]), 64'h0);
        repeat (3) step();
        check("bp_stable", 64'(linkWord()), 64'(exp_q[0]));
        bus.link_ready = 1'b1;
        while (exp_q.size() > 0) begin
            expWord = exp_q.pop_front();
            check("drain_valid", 64'(bus.link_valid), 64'h1);
            check("drain_word", 64'(linkWord()), 64'(expWord));
            step();
        end
        check("drain_idle", 64'(bus.link_valid), 64'h0);
        check("drain_ready", 64'(bus.req_ready), 64'hF);

        // 4: port2 read returns data and unblocks the queued write
        setReq(2, 1'b0, 12'h123, 32'h0);
        step();
        setReq(2, 1'b1, 12'h124, 32'h0000_0055);
        step();
        bus.req_valid = '0;
        check("rd_link_read", 64'(bus.link_read), 64'h1);
        check("rd_link_word", 64'(linkWord()), 64'(mkWord(2, 1'b0, 12'h123, 32'h0)));
        step();
        check("rd_wait", 64'(bus.dbgWaitRsp), 64'h4);
        repeat (9) step();
        check("rd_blocked", 64'(bus.link_valid), 64'h0);
        sendRsp(2'd2, 32'hDEAD_BEEF);
        check("rd_readReady", 64'(bus.readReady), 64'h4);
        check("rd_dataOut", 64'(bus.dataOut[2*DW +: DW]), 64'hDEAD_BEEF);
        check("rd_unexp_quiet", 64'(bus.rsp_unexpected), 64'h0);
        step();
        check("rd_pulse_end", 64'(bus.readReady), 64'h0);
        check("rd_write_word", 64'(linkWord()), 64'(mkWord(2, 1'b1, 12'h124, 32'h0000_0055)));
        check("rd_write_valid", 64'(bus.link_valid), 64'h1);
        step();
        check("rd_link_idle", 64'(bus.link_valid), 64'h0);

        // 5: port0 read with no response times out
        setReq(0, 1'b0, 12'h200, 32'h0);
        step();
        bus.req_valid = '0;
        step();
        check("to_link_read", 64'(bus.link_read), 64'h1);
        step();
        repeat (TO - 1) step();
        check("to_early", 64'(bus.rd_timeout), 64'h0);
        step();
        check("to_pulse", 64'(bus.rd_timeout), 64'h1);
        check("to_no_ready", 64'(bus.readReady), 64'h0);
        check("to_idle", 64'(bus.dbgWaitRsp), 64'h0);
        step();
        check("to_pulse_end", 64'(bus.rd_timeout), 64'h0);
        sendRsp(2'd0, 32'h0000_1234);
        check("late_unexpected", 64'(bus.rsp_unexpected), 64'h1);
        check("late_no_ready", 64'(bus.readReady), 64'h0);
        check("late_dataOut", 64'(bus.dataOut[DW-1:0]), 64'h0);
        step();
        check("late_pulse_end", 64'(bus.rsp_unexpected), 64'h0);

        // 6a: response lands on the timeout cycle and wins
        setReq(1, 1'b0, 12'h300, 32'h0);
        step();
        bus.req_valid = '0;
        repeat (2) step();
        repeat (TO - 1) step();
        sendRsp(2'd1, 32'hCAFE_F00D);
        check("race_ready", 64'(bus.readReady), 64'h2);
        check("race_no_timeout", 64'(bus.rd_timeout), 64'h0);
        check("race_data", 64'(bus.dataOut[DW +: DW]), 64'hCAFE_F00D);
        check("race_unexp", 64'(bus.rsp_unexpected), 64'h0);

        // 6b: reset with port3 waiting and the link stalled
        setReq(3, 1'b0, 12'h3FF, 32'h0);
        step();
        bus.req_valid = '0;
        repeat (2) step();
        check("mid_wait", 64'(bus.dbgWaitRsp), 64'h8);
        bus.link_ready = 1'b0;
        setReq(0, 1'b1, 12'h0AA, 32'h0000_00AA);
        step();
        bus.req_valid = '0;
        setReq(2, 1'b1, 12'h2AA, 32'h0000_02AA);
        step();
        bus.req_valid = '0;
        check("mid_stalled", 64'(bus.link_valid), 64'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_link", 64'(bus.link_valid), 64'h0);
        check("mid_rst_wait", 64'(bus.dbgWaitRsp), 64'h0);
        check("mid_rst_ready", 64'(bus.req_ready), 64'hF);
        step();
        reset = 1'b1;
        bus.link_ready = 1'b1;
        repeat (3) step();
        check("mid_fifo_flushed", 64'(bus.link_valid), 64'h0);
        sendRsp(2'd3, 32'h0BAD_0BAD);
        check("mid_late_unexp", 64'(bus.rsp_unexpected), 64'h1);
        check("mid_late_ready", 64'(bus.readReady), 64'h0);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
